// File: rtl/pwm_multichannel.sv
// -----------------------------------------------------------------------------
// pwm_multichannel
// Multi-channel PWM generator. All NOS_CHANNELS outputs share one period
// counter, which runs edge-aligned (0..P-1) or centre-aligned (0..P..1).
// PERIOD and ON_TIME are double-buffered: bus writes land in shadow registers.
// The shadows are copied into the active registers at the period load point,
// so a timing change never cuts a pulse short.
//
// Register map (word offsets from `PWM_BASE + PWM_UNIT*(3+NOS_CHANNELS)):
//   0 PERIOD (shadow), 1 CONFIG, 2 STATUS (read-only), 3+i ON_TIME[i] (shadow)
//
// Ports (flattened IO_bus):
//   clk, reset                 clock / asynchronous active-low reset
//   reg_address_i              register address
//   register_address_valid_i   address qualifier
//   data_out_i                 write data from the bus master
//   data_in_o                  read data, 'z when this block is not addressed
//   rw_i                       1 = write
//   read_word_from_bus_i       write strobe (block takes a word from the bus)
//   write_data_word_to_bus_i   register read strobe
//   write_status_word_to_bus_i status read strobe (always returns STATUS)
//   nfault_o                   open-drain style fault/irq line
//   pwm_out                    registered PWM outputs
//   period_sync                one-clk pulse after each shadow-load point
//
// Macros:
//   PWM_BASE           bus base address of unit 0 (defaults to 16'h0100)
//   PWM_PERIOD_IRQ_EN  adds the sticky period irq (STATUS[18]), which drives
//                      nfault_o low while CONFIG[3] is set
// -----------------------------------------------------------------------------
`ifndef PWM_BASE
`define PWM_BASE 16'h0100
`endif

module pwm_multichannel #(
  parameter int PWM_UNIT     = 0,
  parameter int NOS_CHANNELS = 4,
  parameter int CNT_WIDTH    = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             reg_address_i,
  input  logic                    register_address_valid_i,
  input  logic [31:0]             data_out_i,
  output logic [31:0]             data_in_o,
  input  logic                    rw_i,
  input  logic                    read_word_from_bus_i,
  input  logic                    write_data_word_to_bus_i,
  input  logic                    write_status_word_to_bus_i,
  output logic                    nfault_o,
  output logic [NOS_CHANNELS-1:0] pwm_out,
  output logic                    period_sync
);

  localparam int                   BASE_C    = int'(`PWM_BASE) + PWM_UNIT * (3 + NOS_CHANNELS);
  localparam logic [15:0]          ADDR_LO_C = 16'(BASE_C);
  localparam logic [15:0]          ADDR_HI_C = 16'(BASE_C + 2 + NOS_CHANNELS);
  localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_UP = 2'd1, S_DOWN = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic [CNT_WIDTH-1:0]    per_s_q, per_a_q;
  logic [CNT_WIDTH-1:0]    on_s_q [NOS_CHANNELS];
  logic [CNT_WIDTH-1:0]    on_a_q [NOS_CHANNELS];
  logic [31:0]             config_q;
  logic                    pending_q;
  logic                    sync_q;
  logic [NOS_CHANNELS-1:0] pwm_q, pwm_d;

  logic                    addressed_s, wr_s, wr_timing_s, stat_rd_s;
  logic                    load_pt_s, start_s, irq_s, running_s;
  logic [15:0]             offset_s;
  logic [CNT_WIDTH-1:0]    on_rd_s;
  logic [31:0]             status_s, rdata_s;

  assign addressed_s = register_address_valid_i &&
                       (reg_address_i >= ADDR_LO_C) && (reg_address_i <= ADDR_HI_C);
  assign offset_s    = reg_address_i - ADDR_LO_C;
  assign wr_s        = addressed_s && read_word_from_bus_i && rw_i;
  assign wr_timing_s = wr_s && ((offset_s == 16'd0) || (offset_s >= 16'd3));
  assign stat_rd_s   = addressed_s && write_data_word_to_bus_i && (offset_s == 16'd2);
  // A zero active period is treated like IDLE so outputs never see a P=0 compare.
  assign running_s   = (state_q != S_IDLE) && (per_a_q != '0);

  // Shadow timing registers and CONFIG, written from the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_s_q  <= '0;
      config_q <= 32'd0;
      for (int i = 0; i < NOS_CHANNELS; i++) on_s_q[i] <= '0;
    end else if (wr_s) begin
      if (offset_s == 16'd0) per_s_q <= data_out_i[CNT_WIDTH-1:0];
      if (offset_s == 16'd1) config_q <= data_out_i;
      for (int i = 0; i < NOS_CHANNELS; i++)
        if (offset_s == 16'(3 + i)) on_s_q[i] <= data_out_i[CNT_WIDTH-1:0];
    end
  end

  // Counter state machine: next state, next count and load-point detection.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    load_pt_s = 1'b0;
    start_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (config_q[0] && (per_s_q != '0)) begin
          start_s = 1'b1;
          state_d = S_UP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_UP: begin
        if (!config_q[0] || (per_a_q == '0)) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (!config_q[1]) begin
          // >= rather than == so a mode change mid-run cannot run the count away.
          if (count_q >= per_a_q - ONE_C) begin
            load_pt_s = 1'b1;
            count_d   = '0;
          end else begin
            count_d = count_q + ONE_C;
          end
        end else if (count_q >= per_a_q) begin
          // With P=1 there is no DOWN leg; the top of the count is the load point.
          if (per_a_q == ONE_C) begin
            load_pt_s = 1'b1;
            count_d   = '0;
          end else begin
            state_d = S_DOWN;
            count_d = per_a_q - ONE_C;
          end
        end else begin
          count_d = count_q + ONE_C;
        end
      end
      S_DOWN: begin
        if (!config_q[0] || (per_a_q == '0)) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (count_q <= ONE_C) begin
          load_pt_s = 1'b1;
          state_d   = S_UP;
          count_d   = '0;
        end else begin
          count_d = count_q - ONE_C;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Compare stage; ON >= P forces active so centre mode has no dip at count P.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NOS_CHANNELS; i++)
      pwm_d[i] = running_s
               ? ((((count_q < on_a_q[i]) || (on_a_q[i] >= per_a_q)) && config_q[8 + i]) ^ config_q[2])
               : config_q[2];
  end

  // Counter, active registers, pending flag and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      per_a_q   <= '0;
      pending_q <= 1'b0;
      sync_q    <= 1'b0;
      pwm_q     <= '0;
      for (int i = 0; i < NOS_CHANNELS; i++) on_a_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sync_q  <= load_pt_s;
      pwm_q   <= pwm_d;
      if (load_pt_s || start_s) begin
        per_a_q <= per_s_q;
        for (int i = 0; i < NOS_CHANNELS; i++) on_a_q[i] <= on_s_q[i];
      end
      // A write coinciding with a load wins: its value waits for the next load.
      if (wr_timing_s)                 pending_q <= 1'b1;
      else if (load_pt_s || start_s)   pending_q <= 1'b0;
    end
  end

`ifdef PWM_PERIOD_IRQ_EN
  logic irq_q;

  // Sticky period irq; a set on the same cycle as a STATUS read wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          irq_q <= 1'b0;
    else if (load_pt_s)  irq_q <= 1'b1;
    else if (stat_rd_s)  irq_q <= 1'b0;
  end

  assign irq_s    = irq_q;
  assign nfault_o = (irq_q && config_q[3]) ? 1'b0 : 1'bz;
`else
  assign irq_s    = 1'b0;
  assign nfault_o = 1'bz;
`endif

  // ON_TIME shadow read-back mux.
  always_comb begin
    on_rd_s = '0;
    for (int i = 0; i < NOS_CHANNELS; i++)
      on_rd_s = on_rd_s | ((offset_s == 16'(3 + i)) ? on_s_q[i] : '0);
  end

  // STATUS word and read-data selection.
  always_comb begin
    status_s                    = 32'd0;
    status_s[NOS_CHANNELS-1:0]  = pwm_q;
    status_s[16]                = pending_q;
    status_s[17]                = (state_q == S_DOWN);
    status_s[18]                = irq_s;
    if (write_status_word_to_bus_i) rdata_s = status_s;
    else if (offset_s == 16'd0)     rdata_s = 32'(per_s_q);
    else if (offset_s == 16'd1)     rdata_s = config_q;
    else if (offset_s == 16'd2)     rdata_s = status_s;
    else                            rdata_s = 32'(on_rd_s);
  end

  assign data_in_o   = addressed_s ? rdata_s : 32'bz;
  assign pwm_out     = pwm_q;
  assign period_sync = sync_q;

  logic unused_s;
  assign unused_s = stat_rd_s;

endmodule
